// File: rtl/cplx_rescale_pipe.sv
// cplx_rescale_pipe: two-stage complex rescaler that sits after the complex multiplier.
//   S1: arithmetic right shift by a runtime amount with round-half-up (toward +inf).
//   S2: narrowing to OUT_W with overflow detection and a sticky overflow flag.
// Handshake: a beat moves on an edge where valid && ready are both high. The producer
//   holds its valid and data stable until the beat is taken. While out_valid_o is high
//   and out_ready_i is low, x_re_o, x_im_o and out_valid_o do not change.
// Build option: define CPLX_RESCALE_SAT_EN to saturate overflowing values. With it
//   undefined, overflowing values wrap (only the low OUT_W bits are kept).
module cplx_rescale_pipe #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 32,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [IN_W-1:0]    x_re_i,
    input  logic [IN_W-1:0]    x_im_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [OUT_W-1:0]   x_re_o,
    output logic [OUT_W-1:0]   x_im_o,
    output logic               ovf_o,
    input  logic               ovf_clr_i
);

    // One guard bit so the rounding add can never overflow.
    localparam int YW = IN_W + 1;

    logic                 s1_valid;
    logic signed [YW-1:0] s1_re;
    logic signed [YW-1:0] s1_im;
    logic                 s2_valid;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 accept;
    logic                 ovf_set;
    logic [31:0]          sh_eff;
    logic [OUT_W:0]       n_re;
    logic [OUT_W:0]       n_im;

    // Round-half-up arithmetic right shift. The result is sign-extended to YW bits.
    function automatic logic signed [YW-1:0] rnd_shift(input logic [IN_W-1:0] x,
                                                       input logic [31:0] s);
        logic signed [YW-1:0] xe;
        logic signed [YW-1:0] half;
        xe = {x[IN_W-1], x};
        if (s == 32'd0) begin
            return xe;
        end
        half = {{(YW-1){1'b0}}, 1'b1} << (s - 32'd1);
        return (xe + half) >>> s;
    endfunction

    // Narrow to OUT_W. Returns {overflow, value}.
    function automatic logic [OUT_W:0] narrow(input logic signed [YW-1:0] y);
        logic [YW-OUT_W:0] top;
        logic              ov;
        logic [OUT_W-1:0]  val;
        top = y[YW-1:OUT_W-1];
        // The value fits only when every bit from the OUT_W sign bit upward is identical.
        ov  = !((&top) || !(|top));
        val = y[OUT_W-1:0];
`ifdef CPLX_RESCALE_SAT_EN
        if (ov) begin
            val = y[YW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
`endif
        return {ov, val};
    endfunction

    // Shift amounts larger than IN_W-1 would leave only sign bits, so they are clamped to IN_W-1.
    assign sh_eff = (32'(shift_i) > 32'(IN_W - 1)) ? 32'(IN_W - 1) : 32'(shift_i);

    // Stage advance conditions: a stage may load when it is empty or its content moves on.
    assign s2_adv     = !s2_valid || out_ready_i;
    assign s1_adv     = !s1_valid || s2_adv;
    assign in_ready_o = !rst && s1_adv;
    assign accept     = in_valid_i && in_ready_o;

    assign n_re    = narrow(s1_re);
    assign n_im    = narrow(s1_im);
    assign ovf_set = s2_adv && s1_valid && (n_re[OUT_W] || n_im[OUT_W]);

    assign out_valid_o = s2_valid;

    // S1: capture the shifted and rounded beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_re <= rnd_shift(x_re_i, sh_eff);
                s1_im <= rnd_shift(x_im_i, sh_eff);
            end
        end
    end

    // S2: narrow and drive the outputs, holding them while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            x_re_o   <= '0;
            x_im_o   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                x_re_o <= n_re[OUT_W-1:0];
                x_im_o <= n_im[OUT_W-1:0];
            end
        end
    end

    // Sticky overflow flag. A new overflow takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else if (ovf_set) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

endmodule
